uart_char_source: RTL and testbench

UART_CHAR_SOURCE -- requirements
Module: uart_char_source

---
 rtl/uart_char_source.sv | 145 ++++++++++++++
 tb/tb_uart_char_source.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_char_source.sv
// 8N1 UART receiver that emits each correctly framed byte as a one-clock write strobe
// plus registered character code, for driving a character feeder.
module uart_char_source #(
  parameter int unsigned CLK_FREQ = 100000000,
  parameter int unsigned BAUD     = 9600
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] character_id_out,
  output logic       we,
  output logic       frame_err,
  output logic       busy
);

  localparam int unsigned DivRaw = CLK_FREQ / (BAUD * 16);
  localparam int unsigned Div    = (DivRaw == 0) ? 1 : DivRaw;
  localparam int unsigned CntW   = (Div > 1) ? $clog2(Div) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(Div - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StWaitHigh
  } state_e;

  state_e          state_q, state_d;
  logic            rx_meta, rx_sync;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            tick;
  logic            cnt_restart;
  logic [3:0]      sample_q, sample_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      char_q, char_d;
  logic            we_q, we_d;
  logic            ferr_q, ferr_d;

  assign tick = (cnt_q == CntLast);

  always_comb begin
    cnt_d = (cnt_restart || tick) ? '0 : cnt_q + CntW'(1);
  end

  always_comb begin
    state_d     = state_q;
    sample_d    = sample_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    char_d      = char_q;
    we_d        = 1'b0;
    ferr_d      = 1'b0;
    cnt_restart = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!rx_sync) begin
          // Realign the oversample phase to the start edge.
          state_d     = StStart;
          sample_d    = 4'd0;
          bit_idx_d   = 3'd0;
          cnt_restart = 1'b1;
        end
      end
      StStart: begin
        if (tick) begin
          if (sample_q == 4'd7) begin
            sample_d = 4'd0;
            state_d  = rx_sync ? StIdle : StData;
          end else begin
            sample_d = sample_q + 4'd1;
          end
        end
      end
      StData: begin
        if (tick) begin
          sample_d = sample_q + 4'd1;
          if (sample_q == 4'd15) begin
            shift_d[bit_idx_q] = rx_sync;
            if (bit_idx_q == 3'd7) begin
              state_d = StStop;
            end else begin
              bit_idx_d = bit_idx_q + 3'd1;
            end
          end
        end
      end
      StStop: begin
        if (tick) begin
          sample_d = sample_q + 4'd1;
          if (sample_q == 4'd15) begin
            // Leaving mid-stop-bit lets a back-to-back start edge be caught.
            if (rx_sync) begin
              char_d  = shift_q;
              we_d    = 1'b1;
              state_d = StIdle;
            end else begin
              ferr_d  = 1'b1;
              state_d = StWaitHigh;
            end
          end
        end
      end
      StWaitHigh: begin
        if (tick && rx_sync) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta   <= 1'b1;
      rx_sync   <= 1'b1;
      state_q   <= StIdle;
      cnt_q     <= '0;
      sample_q  <= 4'd0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'h00;
      char_q    <= 8'h00;
      we_q      <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      rx_meta   <= rx;
      rx_sync   <= rx_meta;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sample_q  <= sample_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      char_q    <= char_d;
      we_q      <= we_d;
      ferr_q    <= ferr_d;
    end
  end

  assign character_id_out = char_q;
  assign we               = we_q;
  assign frame_err        = ferr_q;
  assign busy             = (state_q != StIdle);

endmodule

// File: tb/tb_uart_char_source.sv
// Directed bench for uart_char_source at a scaled clock: 4 clk per tick, 64 clk per bit.
module tb_uart_char_source;

  localparam int unsigned ClkFreq = 1000000;
  localparam int unsigned Baud    = 15625;
  localparam int          BitClks = 64;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic [7:0] character_id_out;
  logic       we;
  logic       frame_err;
  logic       busy;

  uart_char_source #(
    .CLK_FREQ(ClkFreq),
    .BAUD    (Baud)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .rx              (rx),
    .character_id_out(character_id_out),
    .we              (we),
    .frame_err       (frame_err),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Pulse monitor.
  int         cyc = 0;
  int         we_cnt = 0;
  int         fe_cnt = 0;
  int         last_we_cyc = 0;
  int         prev_we_cyc = 0;
  logic [7:0] last_char = 8'h00;
  logic [7:0] prev_char = 8'h00;
  logic       we_prev = 1'b0;
  logic       fe_prev = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (we || frame_err) check("we_ferr_exclusive", {31'd0, we && frame_err}, 32'd0);
    if (we) begin
      check("we_width", {31'd0, we_prev}, 32'd0);
      we_cnt++;
      prev_char   = last_char;
      last_char   = character_id_out;
      prev_we_cyc = last_we_cyc;
      last_we_cyc = cyc;
    end
    if (frame_err) begin
      check("ferr_width", {31'd0, fe_prev}, 32'd0);
      fe_cnt++;
    end
    we_prev = we;
    fe_prev = frame_err;
  end

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (BitClks) @(negedge clk);
  endtask

  task automatic idle_bits(input int n);
    rx = 1'b1;
    repeat (n * BitClks) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(stop);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         exp_we;
    int         exp_fe;
    logic [7:0] exp_char;
  } vec_t;

  vec_t       vecs[7];
  int         w0, f0, lat;
  logic [7:0] d99;

  initial begin
    vecs[0] = '{8'h3C, 1'b0, 0, 1, 8'h41};
    vecs[1] = '{8'h31, 1'b1, 1, 0, 8'h31};
    vecs[2] = '{8'h00, 1'b1, 1, 0, 8'h00};
    vecs[3] = '{8'hFF, 1'b1, 1, 0, 8'hFF};
    vecs[4] = '{8'hA5, 1'b0, 0, 1, 8'hFF};
    vecs[5] = '{8'h80, 1'b1, 1, 0, 8'h80};
    vecs[6] = '{8'h01, 1'b1, 1, 0, 8'h01};

    // Reset state.
    repeat (5) @(negedge clk);
    check("rst_char", {24'd0, character_id_out}, 32'h00);
    check("rst_we", {31'd0, we}, 32'd0);
    check("rst_ferr", {31'd0, frame_err}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    idle_bits(2);

    // 0x41 with start-edge-to-we latency: 2 sync + 1 detect + 9.5 bits = 611 clk.
    w0 = we_cnt; f0 = fe_cnt; lat = 0;
    fork
      send_frame(8'h41, 1'b1);
      begin
        while (!we && lat < 2000) begin
          @(negedge clk);
          lat++;
        end
      end
    join
    idle_bits(2);
    check("lat_41", lat, 611);
    check("we_41", we_cnt - w0, 1);
    check("ferr_41", fe_cnt - f0, 0);
    check("char_41", {24'd0, character_id_out}, 32'h41);

    // Table of single frames, including bad stop bits.
    for (int i = 0; i < 7; i++) begin
      w0 = we_cnt; f0 = fe_cnt;
      send_frame(vecs[i].data, vecs[i].stop);
      idle_bits(2);
      check("tbl_we", we_cnt - w0, vecs[i].exp_we);
      check("tbl_ferr", fe_cnt - f0, vecs[i].exp_fe);
      check("tbl_char", {24'd0, character_id_out}, {24'd0, vecs[i].exp_char});
    end

    // Back-to-back frames.
    w0 = we_cnt; f0 = fe_cnt;
    send_frame(8'h55, 1'b1);
    send_frame(8'hAA, 1'b1);
    idle_bits(2);
    check("b2b_we", we_cnt - w0, 2);
    check("b2b_first", {24'd0, prev_char}, 32'h55);
    check("b2b_second", {24'd0, last_char}, 32'hAA);
    check("b2b_gap", last_we_cyc - prev_we_cyc, 640);
    check("b2b_ferr", fe_cnt - f0, 0);

    // Short low glitch: false start, back to idle at the 8th tick.
    w0 = we_cnt; f0 = fe_cnt;
    rx = 1'b0;
    repeat (10) @(negedge clk);
    check("glitch_busy_hi", {31'd0, busy}, 32'd1);
    repeat (10) @(negedge clk);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    check("glitch_busy_lo", {31'd0, busy}, 32'd0);
    idle_bits(2);
    check("glitch_we", we_cnt - w0, 0);
    check("glitch_ferr", fe_cnt - f0, 0);

    // Break: line held low for 5 frames.
    w0 = we_cnt; f0 = fe_cnt;
    rx = 1'b0;
    repeat (5 * 10 * BitClks) @(negedge clk);
    check("break_busy", {31'd0, busy}, 32'd1);
    idle_bits(2);
    check("break_we", we_cnt - w0, 0);
    check("break_ferr", fe_cnt - f0, 1);
    check("break_char", {24'd0, character_id_out}, 32'hAA);
    w0 = we_cnt;
    send_frame(8'h7E, 1'b1);
    idle_bits(2);
    check("post_break_we", we_cnt - w0, 1);
    check("post_break_char", {24'd0, character_id_out}, 32'h7E);

    // One-clk reset in the middle of bit 4 of 0x99; the sender then aborts.
    w0 = we_cnt; f0 = fe_cnt;
    d99 = 8'h99;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(d99[i]);
    rx = d99[4];
    repeat (BitClks / 2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_char", {24'd0, character_id_out}, 32'h00);
    check("midrst_we", {31'd0, we}, 32'd0);
    check("midrst_ferr", {31'd0, frame_err}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    idle_bits(10);
    check("midrst_no_we", we_cnt - w0, 0);
    check("midrst_no_ferr", fe_cnt - f0, 0);
    send_frame(8'h12, 1'b1);
    idle_bits(2);
    check("post_rst_we", we_cnt - w0, 1);
    check("post_rst_char", {24'd0, character_id_out}, 32'h12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
